// File: rtl/gpu_char_writer_if.sv
// Command handshake and framebuffer port bundle for gpu_char_writer.
interface gpu_char_writer_if #(
    parameter int unsigned framebufferSizeAddress = 11
);
    logic                              cmdValid;
    logic                              cmdReady;
    logic [1:0]                        cmdOp;
    logic [12:0]                       cmdIndex;
    logic [15:0]                       cmdChar;
    logic [framebufferSizeAddress-1:0] fbAddress;
    logic [63:0]                       fbIn;
    logic                              fbWrite;
    logic [63:0]                       fbOut;
    logic                              busy;

    modport slave (
        input  cmdValid, cmdOp, cmdIndex, cmdChar, fbOut,
        output cmdReady, fbAddress, fbIn, fbWrite, busy
    );

    modport master (
        output cmdValid, cmdOp, cmdIndex, cmdChar, fbOut,
        input  cmdReady, fbAddress, fbIn, fbWrite, busy
    );
endinterface

// File: rtl/gpu_char_writer.sv
// Text framebuffer command front end: WRITE (read-modify-write of one lane),
// CLEAR (bulk fill) and SCROLL (row copy plus bottom-row fill).
module gpu_char_writer #(
    parameter int unsigned framebufferSize        = 1200,
    parameter int unsigned framebufferSizeAddress = 11,
    parameter int unsigned rowWords               = 20
) (
    input  logic                clock,
    input  logic                reset_n,
    gpu_char_writer_if.slave    bus
);
    localparam int unsigned AW = framebufferSizeAddress;
    localparam logic [AW-1:0] LAST_WORD  = AW'(framebufferSize - 1);
    localparam logic [AW-1:0] SCR_LAST   = AW'(framebufferSize - rowWords - 1);
    localparam logic [AW-1:0] FILL_START = AW'(framebufferSize - rowWords);
    localparam logic [AW-1:0] ROW        = AW'(rowWords);
    localparam logic [12:0]   CHAR_COUNT = 13'(framebufferSize * 4);

    typedef enum logic [2:0] {IDLE, WR_RD, CLR, SCR_RD, SCR_WR, SCR_FILL} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [15:0]   char_q, char_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic [63:0]   fill_word;

    assign fill_word     = {4{char_q}};
    assign bus.cmdReady  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.fbAddress = addr_q;
    assign bus.fbIn      = data_q;
    assign bus.fbWrite   = wr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            char_q  <= '0;
            lane_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

    // Outputs are computed one cycle ahead so fbAddress/fbIn/fbWrite leave registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmdValid) begin
                    char_d = bus.cmdChar;
                    lane_d = bus.cmdIndex[1:0];
                    case (bus.cmdOp)
                        2'b00: begin
                            if (bus.cmdIndex < CHAR_COUNT) begin
                                state_d = WR_RD;
                                addr_d  = AW'(bus.cmdIndex >> 2);
                            end
                        end
                        2'b01: begin
                            state_d = CLR;
                            cnt_d   = '0;
                            addr_d  = '0;
                            data_d  = {4{bus.cmdChar}};
                            wr_d    = 1'b1;
                        end
                        2'b10: begin
                            state_d = SCR_RD;
                            cnt_d   = '0;
                            addr_d  = ROW;
                        end
                        default: ;
                    endcase
                end
            end
            WR_RD: begin
                data_d = bus.fbOut;
                case (lane_q)
                    2'd0: data_d[15:0]  = char_q;
                    2'd1: data_d[31:16] = char_q;
                    2'd2: data_d[47:32] = char_q;
                    default: data_d[63:48] = char_q;
                endcase
                wr_d    = 1'b1;
                state_d = IDLE;
            end
            CLR, SCR_FILL: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = cnt_q + 1'b1;
                    data_d = fill_word;
                    wr_d   = 1'b1;
                end
            end
            SCR_RD: begin
                addr_d  = cnt_q;
                data_d  = bus.fbOut;
                wr_d    = 1'b1;
                state_d = SCR_WR;
            end
            SCR_WR: begin
                if (cnt_q == SCR_LAST) begin
                    state_d = SCR_FILL;
                    cnt_d   = FILL_START;
                    addr_d  = FILL_START;
                    data_d  = fill_word;
                    wr_d    = 1'b1;
                end else begin
                    state_d = SCR_RD;
                    cnt_d   = cnt_q + 1'b1;
                    addr_d  = cnt_q + ROW + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
